// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side and result side of a 3-stage pipelined ALU.
// Requests are accepted on a valid/ready handshake and their operands go
// straight to the ALU. A tag pipe follows each operation through the ALU.
// The 64-bit result is captured into an in-order FIFO. From there it is
// offered to the register file as a LO/HI writeback.
//
// Handshake rule, used on both sides: a transfer happens on a rising edge
// where valid & ready are both 1. The producer holds valid and its payload
// stable until that transfer. ready never depends combinationally on valid.
//
// Credits: occ counts every operation that has been issued but not yet
// popped, whether it is still in the ALU or already in the FIFO. Issue is
// refused once occ reaches RES_DEPTH, so a result always has a free FIFO slot
// when it arrives.
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 3,
    parameter int RES_DEPTH   = 8,
    parameter int DEST_W      = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_opcode,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [DEST_W-1:0] req_dest,
    output logic [31:0]       alu_A,
    output logic [31:0]       alu_B,
    output logic [4:0]        alu_opcode,
    input  logic [63:0]       alu_C,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DEST_W-1:0] wb_dest,
    output logic [31:0]       wb_lo,
    output logic [31:0]       wb_hi,
    output logic              wb_hi_en
);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int OCC_W = $clog2(RES_DEPTH + 1);
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000;

    logic [OCC_W-1:0]       occ;
    logic                   issue;
    logic                   issue_hi;
    logic                   push;
    logic                   pop;

    logic [ALU_LATENCY-1:0] pipe_v;
    logic [ALU_LATENCY-1:0] pipe_hi;
    logic [DEST_W-1:0]      pipe_dest [ALU_LATENCY];

    logic [DEST_W-1:0]      mem_dest [RES_DEPTH];
    logic [63:0]            mem_c    [RES_DEPTH];
    logic [RES_DEPTH-1:0]   mem_hi;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OCC_W-1:0]       fifo_cnt;

    // Ready depends only on registered occupancy, so it has no wb_ready path.
    assign req_ready = ~clear & (occ < OCC_W'(RES_DEPTH));
    assign issue     = req_valid & req_ready;
    assign issue_hi  = (req_opcode == OP_MUL) | (req_opcode == OP_DIV);

    // Idle cycles send zeros, so the ALU produces 0 for those slots.
    assign alu_A      = issue ? req_a      : 32'd0;
    assign alu_B      = issue ? req_b      : 32'd0;
    assign alu_opcode = issue ? req_opcode : 5'd0;

    // The last tag stage lines up with the ALU result on alu_C.
    assign push     = pipe_v[ALU_LATENCY-1];
    assign wb_valid = (fifo_cnt != '0);
    assign pop      = wb_valid & wb_ready;

    // The head is gated by wb_valid, so an empty FIFO shows all-zero writeback.
    assign wb_dest  = wb_valid ? mem_dest[rd_ptr]      : '0;
    assign wb_lo    = wb_valid ? mem_c[rd_ptr][31:0]   : 32'd0;
    assign wb_hi    = wb_valid ? mem_c[rd_ptr][63:32]  : 32'd0;
    assign wb_hi_en = wb_valid ? mem_hi[rd_ptr]        : 1'b0;

    // Credit counter: an issue takes one credit, a pop returns one.
    always_ff @(posedge clk) begin
        if (clear) begin
            occ <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Tag pipe that shifts {valid, dest, hi_en} alongside the ALU stages.
    always_ff @(posedge clk) begin
        if (clear) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= {pipe_v[ALU_LATENCY-2:0], issue};
        end
        pipe_hi      <= {pipe_hi[ALU_LATENCY-2:0], issue_hi};
        pipe_dest[0] <= req_dest;
        for (int i = 1; i < ALU_LATENCY; i++) begin
            pipe_dest[i] <= pipe_dest[i-1];
        end
    end

    // Result storage. Only the pointers are reset, and an empty FIFO masks the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr] <= pipe_dest[ALU_LATENCY-1];
            mem_hi[wr_ptr]   <= pipe_hi[ALU_LATENCY-1];
            mem_c[wr_ptr]    <= alu_C;
        end
    end

    // FIFO pointers and count. Credits guarantee that a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl.
// It contains a 3-stage ALU that results come back from, and an ordered queue
// of expected writebacks. Each entry in that queue carries the cycle in which
// it becomes visible.
module tb_alu_issue_ctrl;
  localparam int DEST_W    = 4;
  localparam int RES_DEPTH = 8;
  localparam int W         = DEST_W + 1 + 64;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clear = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [4:0]        req_opcode = '0;
  logic [31:0]       req_a = '0;
  logic [31:0]       req_b = '0;
  logic [DEST_W-1:0] req_dest = '0;
  logic [31:0]       alu_A;
  logic [31:0]       alu_B;
  logic [4:0]        alu_opcode;
  logic [63:0]       alu_C;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [DEST_W-1:0] wb_dest;
  logic [31:0]       wb_lo;
  logic [31:0]       wb_hi;
  logic              wb_hi_en;

  alu_issue_ctrl #(.ALU_LATENCY(3), .RES_DEPTH(RES_DEPTH), .DEST_W(DEST_W)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .alu_C(alu_C),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
    .wb_lo(wb_lo), .wb_hi(wb_hi), .wb_hi_en(wb_hi_en)
  );

  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] aa;
    logic [4:0]  s;
    aa = {a, a};
    s  = b[4:0];
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a & b};
      5'b00110: return {32'd0, a | b};
      5'b00111: return {32'd0, 32'(aa >> s)};
      5'b01000: begin aa = aa << s; return {32'd0, aa[63:32]}; end
      5'b01001: return {32'd0, a >> s};
      5'b01010: return {32'd0, 32'($signed(a) >>> s)};
      5'b01011: return {32'd0, a << s};
      5'b01111: return (b == 0) ? 64'd0 : {a % b, a / b};
      5'b10000: return {32'd0, a} * {32'd0, b};
      5'b10001: return {32'd0, -b};
      5'b10010: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  function automatic logic [4:0] pick_op(input int i);
    case (i)
      0: return 5'b00011;  1: return 5'b00100;  2: return 5'b00101;
      3: return 5'b00110;  4: return 5'b00111;  5: return 5'b01000;
      6: return 5'b01001;  7: return 5'b01010;  8: return 5'b01011;
      9: return 5'b01111; 10: return 5'b10000; 11: return 5'b10001;
      default: return 5'b10010;
    endcase
  endfunction

  // ALU: operands are captured on the issue edge and the result is on alu_C two edges later
  logic [31:0] a_r, b_r;
  logic [4:0]  op_r;
  logic [63:0] s1_r, c_r;
  always @(posedge clk) begin
    if (clear) begin
      a_r <= '0; b_r <= '0; op_r <= '0; s1_r <= '0; c_r <= '0;
    end else begin
      a_r <= alu_A; b_r <= alu_B; op_r <= alu_opcode;
      s1_r <= alu_f(op_r, a_r, b_r);
      c_r <= s1_r;
    end
  end
  assign alu_C = c_r;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           dut_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge, checks against the model, then advances one cycle.
  task automatic cycle();
    logic         exp_ready, exp_valid, issue_e, hi_e;
    logic [W-1:0] head;
    @(negedge clk);
    exp_ready = !clear && (exp_q.size() < RES_DEPTH);
    issue_e   = req_valid && exp_ready;
    exp_valid = (exp_q.size() > 0) && (due_q[0] <= cyc);
    if (req_valid && req_ready) dut_acc++;
    check("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
    check("alu_A", {32'd0, alu_A}, issue_e ? {32'd0, req_a} : 64'd0);
    check("alu_B", {32'd0, alu_B}, issue_e ? {32'd0, req_b} : 64'd0);
    check("alu_opcode", {59'd0, alu_opcode}, issue_e ? {59'd0, req_opcode} : 64'd0);
    check("wb_valid", {63'd0, wb_valid}, {63'd0, exp_valid});
    if (exp_valid) begin
      head = exp_q[0];
      check("wb_dest", {60'd0, wb_dest}, {60'd0, head[W-1 -: DEST_W]});
      check("wb_hi_en", {63'd0, wb_hi_en}, {63'd0, head[64]});
      check("wb_lo", {32'd0, wb_lo}, {32'd0, head[31:0]});
      check("wb_hi", {32'd0, wb_hi}, {32'd0, head[63:32]});
      if (wb_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
    if (issue_e) begin
      hi_e = (req_opcode == 5'b10000) || (req_opcode == 5'b01111);
      exp_q.push_back({req_dest, hi_e, alu_f(req_opcode, req_a, req_b)});
      due_q.push_back(cyc + 4);
    end
    if (clear) begin
      exp_q.delete();
      due_q.delete();
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [DEST_W-1:0] d);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_dest = d;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_dest"}, {60'd0, wb_dest}, 64'd0);
    check({tag, "_lo"}, {32'd0, wb_lo}, 64'd0);
    check({tag, "_hi"}, {32'd0, wb_hi}, 64'd0);
    check({tag, "_hi_en"}, {63'd0, wb_hi_en}, 64'd0);
  endtask

  initial begin
    // reset: two clear cycles; the first edge initialises the DUT
    @(posedge clk); #1;
    cycle();
    check_wb_zero("rst");
    clear = 1'b0;
    wb_ready = 1'b1;
    cycle();

    // ADD 5+7 -> dest 3, then MUL 0x10000*0x10000 -> dest 5
    drive_req(5'b00011, 32'd5, 32'd7, 4'd3);
    cycle();
    idle(6);
    drive_req(5'b10000, 32'h0001_0000, 32'h0001_0000, 4'd5);
    cycle();
    idle(6);

    // backpressure: 10 back-to-back ADDs with the register file stalled
    wb_ready = 1'b0;
    dut_acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive_req(5'b00011, 32'(i), 32'd100, 4'(i));
      cycle();
    end
    check("bp_accepted", 64'(dut_acc), 64'd8);
    idle(2);
    wb_ready = 1'b1;
    idle(12);

    // clear with two ops in flight and one queued
    wb_ready = 1'b0;
    drive_req(5'b00011, 32'd1, 32'd1, 4'd1);
    cycle();
    idle(2);
    drive_req(5'b00011, 32'd2, 32'd2, 4'd2);
    cycle();
    drive_req(5'b00011, 32'd3, 32'd3, 4'd4);
    cycle();
    req_valid = 1'b0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check_wb_zero("clr");
    wb_ready = 1'b1;
    idle(8);
    drive_req(5'b00100, 32'd9, 32'd4, 4'd7);
    cycle();
    idle(6);

    // 16-op stream with the register file always ready
    for (int i = 0; i < 16; i++) begin
      drive_req(pick_op($urandom_range(0, 12)), $urandom, $urandom, 4'(i));
      cycle();
    end
    idle(8);

    // random traffic: random valid/ready, any opcode, occasional clear
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_opcode = 5'($urandom);
      req_a      = $urandom;
      req_b      = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req_dest   = 4'($urandom);
      wb_ready   = ($urandom_range(0, 2) != 0);
      clear      = ($urandom_range(0, 79) == 0);
      cycle();
    end
    clear = 1'b0;
    wb_ready = 1'b1;
    idle(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
